// File: rtl/tcam_sram_search.sv
// TCAM emulated in SRAM: the key is split into SUB_W-bit slices, each slice selects one
// row per virtual block, and the rows are ANDed to find matching entries.
// Search response 2 cycles after the command cycle; ready is low only during a clear sweep.
`timescale 1ns/1ps
module tcam_sram_search #(
  parameter  int QUERY_W = 28,
  parameter  int SUB_W   = 7,
  parameter  int ENTRIES = 32,
  localparam int NVTB    = QUERY_W / SUB_W,
  localparam int ROWS    = 2 ** SUB_W,
  localparam int IDX_W   = $clog2(ENTRIES),
  localparam int VTB_W   = (NVTB > 1) ? $clog2(NVTB) : 1,
  localparam int NB      = ENTRIES / 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_op_i,
  input  logic [QUERY_W-1:0] cmd_query_i,
  input  logic [VTB_W-1:0]   cmd_vtb_i,
  input  logic [SUB_W-1:0]   cmd_row_i,
  input  logic [ENTRIES-1:0] cmd_data_i,
  input  logic [NB-1:0]      cmd_wmask_i,
  output logic               rsp_valid_o,
  output logic               rsp_match_o,
  output logic [IDX_W-1:0]   rsp_index_o,
  output logic               rsp_multi_o,
  output logic               busy_o
);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t             r_state;
  logic [SUB_W-1:0]   r_cnt;
  logic               r_ready;
  logic               r_busy;
  logic [ENTRIES-1:0] r_mem [NVTB][ROWS];
  logic [ENTRIES-1:0] r_s1_rows [NVTB];
  logic               r_s1_vld;
  logic               r_rsp_vld;
  logic               r_rsp_match;
  logic               r_rsp_multi;
  logic [IDX_W-1:0]   r_rsp_idx;

  logic               w_acc;
  logic               w_search;
  logic               w_write;
  logic               w_clear;
  logic [ENTRIES-1:0] w_and;
  logic [IDX_W-1:0]   w_idx;
  logic               w_hit;
  logic               w_multi;

  // Command decode; writes to a non-existent VTB are accepted but dropped.
  assign w_acc    = cmd_valid_i && r_ready;
  assign w_search = w_acc && (cmd_op_i == 2'b00);
  assign w_write  = w_acc && (cmd_op_i == 2'b01) && (int'(cmd_vtb_i) < NVTB);
  assign w_clear  = w_acc && (cmd_op_i == 2'b10);

  // Control FSM: reset lands in CLEAR so the array is always swept after power-up.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_clear) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (r_cnt == SUB_W'(ROWS - 1)) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + SUB_W'(1);
          end
        end
      endcase
    end
  end

  // Array update: sweep one row of every VTB per clear cycle, else byte-masked writes.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NVTB; k++) begin
      if (r_state == S_CLEAR) begin
        r_mem[k][r_cnt] <= '0;
      end else if (w_write && (cmd_vtb_i == VTB_W'(k))) begin
        for (int b = 0; b < NB; b++) begin
          if (cmd_wmask_i[b]) begin
            r_mem[k][cmd_row_i][8*b +: 8] <= cmd_data_i[8*b +: 8];
          end
        end
      end
    end
  end

  // Stage 1: capture the selected row of every VTB so later writes/clears cannot disturb it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_vld <= 1'b0;
      for (int k = 0; k < NVTB; k++) r_s1_rows[k] <= '0;
    end else begin
      r_s1_vld <= w_search;
      if (w_search) begin
        for (int k = 0; k < NVTB; k++) begin
          r_s1_rows[k] <= r_mem[k][cmd_query_i[QUERY_W-1-k*SUB_W -: SUB_W]];
        end
      end
    end
  end

  // Stage 2 combinational: AND the rows, lowest set bit wins, multi if more than one bit set.
  always_comb begin
    w_and = '1;
    for (int k = 0; k < NVTB; k++) w_and = w_and & r_s1_rows[k];
    w_idx = '0;
    for (int e = ENTRIES - 1; e >= 0; e--) begin
      if (w_and[e]) w_idx = IDX_W'(e);
    end
    w_hit   = |w_and;
    w_multi = |(w_and & (w_and - ENTRIES'(1)));
  end

  // Response registers: fields only change on a completed search and hold otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_vld   <= 1'b0;
      r_rsp_match <= 1'b0;
      r_rsp_multi <= 1'b0;
      r_rsp_idx   <= '0;
    end else begin
      r_rsp_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_rsp_match <= w_hit;
        r_rsp_multi <= w_multi;
        r_rsp_idx   <= w_idx;
      end
    end
  end

  assign cmd_ready_o = r_ready;
  assign busy_o      = r_busy;
  assign rsp_valid_o = r_rsp_vld;
  assign rsp_match_o = r_rsp_match;
  assign rsp_index_o = r_rsp_idx;
  assign rsp_multi_o = r_rsp_multi;

endmodule

// File: tb/tb_tcam_sram_search.sv
// Bench for tcam_sram_search: directed commands, an abstract array/queue model,
// and a per-cycle compare of every output against that model.
`timescale 1ns/1ps
module tb_tcam_sram_search;

  localparam int ROWS = 128;
  localparam logic [27:0] KEY5 = {4{7'h05}};
  localparam logic [27:0] KEY3 = {4{7'h03}};
  localparam logic [27:0] KEY7 = {4{7'h07}};

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [27:0] cmd_query;
  logic [1:0]  cmd_vtb;
  logic [6:0]  cmd_row;
  logic [31:0] cmd_data;
  logic [3:0]  cmd_wmask;
  logic        rsp_valid;
  logic        rsp_match;
  logic [4:0]  rsp_index;
  logic        rsp_multi;
  logic        busy;

  tcam_sram_search dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_query_i(cmd_query), .cmd_vtb_i(cmd_vtb), .cmd_row_i(cmd_row),
    .cmd_data_i(cmd_data), .cmd_wmask_i(cmd_wmask),
    .rsp_valid_o(rsp_valid), .rsp_match_o(rsp_match), .rsp_index_o(rsp_index),
    .rsp_multi_o(rsp_multi), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {int due; bit m; int idx; bit mu;} exp_t;
  exp_t q[$];
  bit [31:0] mm [4][ROWS];
  int  cyc = 0;
  int  busy_left = ROWS;
  bit  lm = 0;
  int  li = 0;
  bit  lmu = 0;

  function automatic void lookup(input logic [27:0] key, output bit m, output int idx, output bit mu);
    bit [31:0] a;
    a = '1;
    for (int k = 0; k < 4; k++) a = a & mm[k][key[27-7*k -: 7]];
    m = (a != 0);
    idx = 0;
    for (int e = 31; e >= 0; e--) if (a[e]) idx = e;
    mu = ($countones(a) > 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_left = ROWS;
      q.delete();
      lm = 0; li = 0; lmu = 0;
      for (int k = 0; k < 4; k++) for (int r = 0; r < ROWS; r++) mm[k][r] = '0;
    end else begin
      cyc++;
      if (busy_left > 0) begin
        busy_left--;
      end else if (cmd_valid) begin
        case (cmd_op)
          2'b00: begin
            exp_t e;
            lookup(cmd_query, e.m, e.idx, e.mu);
            e.due = cyc + 1;
            q.push_back(e);
          end
          2'b01: begin
            for (int b = 0; b < 4; b++)
              if (cmd_wmask[b]) mm[cmd_vtb][cmd_row][8*b +: 8] = cmd_data[8*b +: 8];
          end
          2'b10: begin
            for (int k = 0; k < 4; k++) for (int r = 0; r < ROWS; r++) mm[k][r] = '0;
            busy_left = ROWS;
          end
          default: ;
        endcase
      end
    end
  end

  // Per-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      bit ev;
      ev = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        ev = 1;
        lm = q[0].m; li = q[0].idx; lmu = q[0].mu;
        void'(q.pop_front());
      end
      chk("cyc_rsp_valid", int'(rsp_valid), int'(ev));
      chk("cyc_rsp_match", int'(rsp_match), int'(lm));
      chk("cyc_rsp_index", int'(rsp_index), li);
      chk("cyc_rsp_multi", int'(rsp_multi), int'(lmu));
      chk("cyc_ready", int'(cmd_ready), int'(busy_left == 0));
      chk("cyc_busy", int'(busy), int'(busy_left > 0));
    end
  end

  int vcount = 0;
  always @(negedge clk) if (rst_n && rsp_valid) vcount++;

  // ---------------- stimulus ----------------
  task automatic issue(input logic [1:0] op, input logic [27:0] key, input logic [1:0] vtb,
                       input logic [6:0] row, input logic [31:0] data, input logic [3:0] mask);
    cmd_valid = 1'b1; cmd_op = op; cmd_query = key; cmd_vtb = vtb;
    cmd_row = row; cmd_data = data; cmd_wmask = mask;
    @(negedge clk);
  endtask

  task automatic idle();
    cmd_valid = 1'b0;
  endtask

  task automatic wr_all(input logic [6:0] row, input logic [31:0] data, input logic [3:0] mask);
    for (int k = 0; k < 4; k++) issue(2'b01, '0, 2'(k), row, data, mask);
  endtask

  task automatic search(input logic [27:0] key);
    issue(2'b00, key, '0, '0, '0, '0);
    idle();
  endtask

  task automatic expect_rsp(input string name, input int m, input int idx, input int mu);
    int n;
    n = 0;
    while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
    chk({name, "_valid"}, int'(rsp_valid), 1);
    chk({name, "_match"}, int'(rsp_match), m);
    chk({name, "_index"}, int'(rsp_index), idx);
    chk({name, "_multi"}, int'(rsp_multi), mu);
    @(negedge clk);
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (busy && n < 400) begin n++; @(negedge clk); end
    chk(name, n, ROWS);
  endtask

  initial begin
    int n, snap;
    logic [27:0] keys [8];
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_query = '0; cmd_vtb = '0;
    cmd_row = '0; cmd_data = '0; cmd_wmask = '0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    chk("reset_busy", int'(busy), 1);
    chk("reset_ready", int'(cmd_ready), 0);
    chk("reset_index", int'(rsp_index), 0);
    rst_n = 1'b1;
    count_busy("boot_clear_cycles");

    search(28'h0ABCDEF);
    expect_rsp("miss_after_boot", 0, 0, 0);

    wr_all(7'h05, 32'h0000_0010, 4'hF);
    search(KEY5);
    expect_rsp("single_hit", 1, 4, 0);

    wr_all(7'h05, 32'h0000_0200, 4'b0010);
    search(KEY5);
    expect_rsp("multi_hit", 1, 4, 1);

    wr_all(7'h05, 32'h0000_0000, 4'b0001);
    search(KEY5);
    expect_rsp("byte0_cleared", 1, 9, 0);

    wr_all(7'h03, 32'h8000_0000, 4'b1000);
    search(KEY3);
    expect_rsp("top_entry", 1, 31, 0);

    wr_all(7'h07, 32'h0000_0001, 4'hF);
    search(KEY7);
    expect_rsp("entry_zero", 1, 0, 0);

    search({KEY5[27:7], 7'h03});
    expect_rsp("partial_miss", 0, 0, 0);

    issue(2'b11, KEY5, '0, 7'h05, 32'hFFFF_FFFF, 4'hF);
    idle();
    search(KEY5);
    expect_rsp("reserved_no_effect", 1, 9, 0);

    keys[0] = KEY5; keys[1] = KEY3; keys[2] = 28'h0ABCDEF; keys[3] = KEY7;
    keys[4] = KEY3; keys[5] = KEY5; keys[6] = KEY7; keys[7] = 28'h1111111;
    snap = vcount;
    for (int i = 0; i < 8; i++) issue(2'b00, keys[i], '0, '0, '0, '0);
    idle();
    repeat (4) @(negedge clk);
    chk("b2b_pulses", vcount - snap, 8);

    issue(2'b00, KEY5, '0, '0, '0, '0);
    issue(2'b10, '0, '0, '0, '0, '0);
    idle();
    expect_rsp("search_before_clear", 1, 9, 0);
    n = 1;
    while (!cmd_ready && n < 400) begin n++; @(negedge clk); end
    chk("clear_ready_low", n, ROWS);
    search(KEY5);
    expect_rsp("miss_after_clear5", 0, 0, 0);
    search(KEY7);
    expect_rsp("miss_after_clear7", 0, 0, 0);

    wr_all(7'h05, 32'h0000_0008, 4'hF);
    search(KEY5);
    expect_rsp("hit_before_reset", 1, 3, 0);
    issue(2'b10, '0, '0, '0, '0, '0);
    idle();
    repeat (59) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_match", int'(rsp_match), 0);
    chk("abort_index", int'(rsp_index), 0);
    chk("abort_busy", int'(busy), 1);
    chk("abort_ready", int'(cmd_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    count_busy("reclear_cycles");

    wr_all(7'h05, 32'h0000_0008, 4'hF);
    issue(2'b00, KEY5, '0, '0, '0, '0);
    idle();
    snap = vcount;
    #2 rst_n = 1'b0;
    #1 chk("midsearch_valid", int'(rsp_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    count_busy("midsearch_reclear");
    chk("aborted_search_no_rsp", vcount - snap, 0);
    search(KEY5);
    expect_rsp("miss_after_reset", 0, 0, 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
